// File: rtl/mips_exec_alu.sv
// 32-bit MIPS execute-stage ALU: combinational result and flags,
// plus HI/LO registers written by multiply, divide and move ops.
module mips_exec_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] out,
  output logic        zero,
  output logic        great,
  output logic        overflow
);

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_ADDU  = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_SUBU  = 6'h03;
  localparam logic [5:0] OP_AND   = 6'h04;
  localparam logic [5:0] OP_OR    = 6'h05;
  localparam logic [5:0] OP_XOR   = 6'h06;
  localparam logic [5:0] OP_NOR   = 6'h07;
  localparam logic [5:0] OP_SLT   = 6'h08;
  localparam logic [5:0] OP_SLTU  = 6'h09;
  localparam logic [5:0] OP_SLL   = 6'h0A;
  localparam logic [5:0] OP_SRL   = 6'h0B;
  localparam logic [5:0] OP_SRA   = 6'h0C;
  localparam logic [5:0] OP_SLLV  = 6'h0D;
  localparam logic [5:0] OP_SRLV  = 6'h0E;
  localparam logic [5:0] OP_SRAV  = 6'h0F;
  localparam logic [5:0] OP_LUI   = 6'h10;
  localparam logic [5:0] OP_MULT  = 6'h11;
  localparam logic [5:0] OP_MULTU = 6'h12;
  localparam logic [5:0] OP_DIV   = 6'h13;
  localparam logic [5:0] OP_DIVU  = 6'h14;
  localparam logic [5:0] OP_MFHI  = 6'h15;
  localparam logic [5:0] OP_MFLO  = 6'h16;
  localparam logic [5:0] OP_MTHI  = 6'h17;
  localparam logic [5:0] OP_MTLO  = 6'h18;

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] w_sum;
  logic [31:0] w_dif;
  logic [4:0]  w_vsh;
  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic [31:0] w_squo;
  logic [31:0] w_srem;
  logic [31:0] w_uquo;
  logic [31:0] w_urem;
  logic        w_dmin;
  logic        w_bz;

  assign w_sum = a + b;
  assign w_dif = a - b;
  assign w_vsh = a[4:0];

  assign zero  = (a == b);
  assign great = ($signed(a) > $signed(b));

  assign w_smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_umul = {32'd0, a} * {32'd0, b};

  // INT_MIN / -1 overflows the signed divider; its MIPS result is fixed.
  assign w_bz   = (b == 32'd0);
  assign w_dmin = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign w_squo = (w_bz || w_dmin) ? a : 32'($signed(a) / $signed(b));
  assign w_srem = (w_bz || w_dmin) ? 32'd0 : 32'($signed(a) % $signed(b));
  assign w_uquo = w_bz ? 32'd0 : a / b;
  assign w_urem = w_bz ? 32'd0 : a % b;

  always_comb begin
    overflow = 1'b0;
    unique case (alu_op)
      OP_ADD: overflow = (a[31] == b[31]) && (w_sum[31] != a[31]);
      OP_SUB: overflow = (a[31] != b[31]) && (w_dif[31] != a[31]);
      default: overflow = 1'b0;
    endcase
  end

  always_comb begin
    out = 32'd0;
    unique case (alu_op)
      OP_ADD, OP_ADDU: out = w_sum;
      OP_SUB, OP_SUBU: out = w_dif;
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      OP_NOR:  out = ~(a | b);
      OP_SLT:  out = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: out = {31'd0, a < b};
      OP_SLL:  out = b << shamt;
      OP_SRL:  out = b >> shamt;
      OP_SRA:  out = $signed(b) >>> shamt;
      OP_SLLV: out = b << w_vsh;
      OP_SRLV: out = b >> w_vsh;
      OP_SRAV: out = $signed(b) >>> w_vsh;
      OP_LUI:  out = {b[15:0], 16'h0000};
      OP_MFHI: out = r_hi;
      OP_MFLO: out = r_lo;
      default: out = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      unique case (alu_op)
        OP_MULT: begin
          r_hi <= w_smul[63:32];
          r_lo <= w_smul[31:0];
        end
        OP_MULTU: begin
          r_hi <= w_umul[63:32];
          r_lo <= w_umul[31:0];
        end
        OP_DIV: if (!w_bz) begin
          r_hi <= w_srem;
          r_lo <= w_squo;
        end
        OP_DIVU: if (!w_bz) begin
          r_hi <= w_urem;
          r_lo <= w_uquo;
        end
        OP_MTHI: r_hi <= a;
        OP_MTLO: r_lo <= a;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_exec_alu.sv
// Bench for mips_exec_alu: directed cases then random ops against
// an arithmetic reference model of the ALU and HI/LO.
module tb_mips_exec_alu;

  logic        clk;
  logic        rst;
  logic [5:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [31:0] out;
  logic        zero;
  logic        great;
  logic        overflow;

  int n_cmp;
  int n_bad;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mips_exec_alu dut (
    .clk(clk), .rst(rst), .alu_op(alu_op),
    .a(a), .b(b), .shamt(shamt),
    .out(out), .zero(zero), .great(great),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint ux(input logic [31:0] v);
    return longint'({32'd0, v});
  endfunction

  function automatic longint pw(input logic [4:0] n);
    return longint'(2) ** longint'(ux({27'd0, n}));
  endfunction

  function automatic logic [31:0] f_shl(input logic [31:0] v,
                                        input logic [4:0] n);
    longint r;
    r = ux(v) * pw(n);
    return r[31:0];
  endfunction

  function automatic logic [31:0] f_shr(input logic [31:0] v,
                                        input logic [4:0] n);
    longint r;
    r = ux(v) / pw(n);
    return r[31:0];
  endfunction

  // arithmetic shift right == floor division by 2^n
  function automatic logic [31:0] f_sra(input logic [31:0] v,
                                        input logic [4:0] n);
    longint r;
    if (sx(v) >= 0) r = sx(v) / pw(n);
    else r = -((-sx(v) + pw(n) - 1) / pw(n));
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_out(input logic [5:0] op,
                                          input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [4:0] s);
    longint r;
    r = 0;
    case (op)
      6'h00, 6'h01: r = ux(x) + ux(y);
      6'h02, 6'h03: r = ux(x) - ux(y);
      6'h04: r = ux(x & y);
      6'h05: r = ux(x | y);
      6'h06: r = ux(x ^ y);
      6'h07: r = ux(~(x | y));
      6'h08: r = (sx(x) < sx(y)) ? 1 : 0;
      6'h09: r = (ux(x) < ux(y)) ? 1 : 0;
      6'h0A: r = ux(f_shl(y, s));
      6'h0B: r = ux(f_shr(y, s));
      6'h0C: r = ux(f_sra(y, s));
      6'h0D: r = ux(f_shl(y, x[4:0]));
      6'h0E: r = ux(f_shr(y, x[4:0]));
      6'h0F: r = ux(f_sra(y, x[4:0]));
      6'h10: r = ux({16'd0, y[15:0]}) * 65536;
      6'h15: r = ux(m_hi);
      6'h16: r = ux(m_lo);
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic ref_ovf(input logic [5:0] op,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
    longint r;
    if (op == 6'h00) r = sx(x) + sx(y);
    else if (op == 6'h02) r = sx(x) - sx(y);
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic ref_update(input logic [5:0] op,
                            input logic [31:0] x,
                            input logic [31:0] y);
    longint p;
    longint q;
    longint rm;
    case (op)
      6'h11: begin
        p = sx(x) * sx(y);
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      6'h12: begin
        p = ux(x) * ux(y);
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      6'h13: if (y != 0) begin
        q = sx(x) / sx(y);
        rm = sx(x) - q * sx(y);
        m_lo = q[31:0]; m_hi = rm[31:0];
      end
      6'h14: if (y != 0) begin
        q = ux(x) / ux(y);
        rm = ux(x) - q * ux(y);
        m_lo = q[31:0]; m_hi = rm[31:0];
      end
      6'h17: m_hi = x;
      6'h18: m_lo = x;
      default: ;
    endcase
  endtask

  // drive, check combinational outputs mid-cycle, then commit at the edge
  task automatic do_op(input logic [5:0] op,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [4:0] s);
    alu_op = op; a = x; b = y; shamt = s;
    @(negedge clk);
    chk($sformatf("out op%02h", op), out, ref_out(op, x, y, s));
    chk($sformatf("ovf op%02h", op), {31'd0, overflow},
        {31'd0, ref_ovf(op, x, y)});
    chk("zero", {31'd0, zero}, {31'd0, x == y});
    chk("great", {31'd0, great}, {31'd0, sx(x) > sx(y)});
    @(posedge clk);
    ref_update(op, x, y);
    #1;
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    n_cmp = 0; n_bad = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    rst = 1'b0;
    alu_op = 6'h15; a = 32'd0; b = 32'd0; shamt = 5'd0;
    #2;
    chk("rst mfhi", out, 32'd0);
    alu_op = 6'h16;
    #1;
    chk("rst mflo", out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_op(6'h00, 32'h7FFF_FFFF, 32'd1, 5'd0);
    chk("add out", out, 32'h8000_0000);
    chk("add ovf", {31'd0, overflow}, 32'd1);
    do_op(6'h01, 32'h7FFF_FFFF, 32'd1, 5'd0);
    chk("addu ovf", {31'd0, overflow}, 32'd0);
    do_op(6'h02, 32'd5, 32'd5, 5'd0);
    chk("sub zero", {31'd0, zero}, 32'd1);
    chk("sub great", {31'd0, great}, 32'd0);
    do_op(6'h08, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk("slt", out, 32'd1);
    do_op(6'h09, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk("sltu", out, 32'd0);
    do_op(6'h0C, 32'd0, 32'h8000_0000, 5'd4);
    chk("sra", out, 32'hF800_0000);
    do_op(6'h0E, 32'd4, 32'h8000_0000, 5'd0);
    chk("srlv", out, 32'h0800_0000);
    do_op(6'h10, 32'd0, 32'h0000_1234, 5'd0);
    chk("lui", out, 32'h1234_0000);

    do_op(6'h11, 32'hFFFF_FFFE, 32'd3, 5'd0);
    do_op(6'h15, 32'd0, 32'd0, 5'd0);
    chk("mult hi", out, 32'hFFFF_FFFF);
    do_op(6'h16, 32'd0, 32'd0, 5'd0);
    chk("mult lo", out, 32'hFFFF_FFFA);
    do_op(6'h12, 32'hFFFF_FFFE, 32'd3, 5'd0);
    do_op(6'h15, 32'd0, 32'd0, 5'd0);
    chk("multu hi", out, 32'h0000_0002);
    do_op(6'h16, 32'd0, 32'd0, 5'd0);
    chk("multu lo", out, 32'hFFFF_FFFA);

    do_op(6'h13, 32'hFFFF_FFF9, 32'd2, 5'd0);
    do_op(6'h14, 32'd9, 32'd0, 5'd0);
    do_op(6'h16, 32'd0, 32'd0, 5'd0);
    chk("div lo", out, 32'hFFFF_FFFD);
    do_op(6'h15, 32'd0, 32'd0, 5'd0);
    chk("div hi", out, 32'hFFFF_FFFF);
    do_op(6'h13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    do_op(6'h16, 32'd0, 32'd0, 5'd0);
    chk("divmin lo", out, 32'h8000_0000);
    do_op(6'h15, 32'd0, 32'd0, 5'd0);
    chk("divmin hi", out, 32'd0);

    // MTHI result must be visible the very next cycle
    do_op(6'h17, 32'hDEAD_BEEF, 32'd0, 5'd0);
    do_op(6'h15, 32'd0, 32'd0, 5'd0);
    chk("mthi", out, 32'hDEAD_BEEF);
    alu_op = 6'h15;
    #2 rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    #1;
    chk("async rst hi", out, 32'd0);
    #2 rst = 1'b1;
    do_op(6'h00, 32'd3, 32'd0, 5'd0);
    chk("br great", {31'd0, great}, 32'd1);
    chk("br zero", {31'd0, zero}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = 6'($urandom_range(0, 24));
      do_op(op, rnd_val(), rnd_val(), 5'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
